// File: rtl/bht_predictor.sv
// Bimodal branch history table: 2-bit saturating counters indexed by word PC,
// combinational fetch prediction, EX-stage resolution and statistics counters.
module bht_predictor #(
  parameter int unsigned ENTRIES = 128,
  parameter int unsigned IDX_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  // Fetch stage
  input  logic [31:0] PCF,
  input  logic        BtbHitF,
  input  logic [31:0] BtbTargetF,
  output logic        PredTakenF,
  output logic [31:0] NPCF,
  // Execute stage
  input  logic [31:0] PCE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  input  logic        StallE,
  output logic        MispredictE,
  output logic [31:0] CorrectPCE,
  // Statistics
  output logic [31:0] BranchCnt,
  output logic [31:0] MissCnt
);

  localparam logic [1:0] CtrWeakNt = 2'b01;
  localparam logic [2:0] NoBranch  = 3'd0;

  logic [1:0]       ctr_q [ENTRIES];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       rd_ctr;
  logic [1:0]       wr_ctr_q;
  logic [1:0]       wr_ctr_d;
  logic             upd;
  logic             dir_miss;
  logic             tgt_miss;
  logic [31:0]      branch_cnt_q;
  logic [31:0]      miss_cnt_q;

  assign rd_idx = PCF[IDX_W+1:2];
  assign wr_idx = PCE[IDX_W+1:2];

  // Fetch read path: no bypass from a same-cycle update.
  assign rd_ctr     = ctr_q[rd_idx];
  assign PredTakenF = BtbHitF & rd_ctr[1];
  assign NPCF       = PredTakenF ? BtbTargetF : PCF + 32'd4;

  // A stalled EX instruction is not resolved yet; it is handled once StallE drops.
  assign upd      = (BranchTypeE != NoBranch) & ~StallE;
  assign dir_miss = BranchTakenE != PredTakenE;
  assign tgt_miss = BranchTakenE & PredTakenE & (PredTargetE != BranchTargetE);

  assign MispredictE = upd & (dir_miss | tgt_miss);
  assign CorrectPCE  = BranchTakenE ? BranchTargetE : PCE + 32'd4;

  assign wr_ctr_q = ctr_q[wr_idx];

  always_comb begin
    wr_ctr_d = wr_ctr_q;
    if (BranchTakenE) begin
      if (wr_ctr_q != 2'b11) wr_ctr_d = wr_ctr_q + 2'b01;
    end else begin
      if (wr_ctr_q != 2'b00) wr_ctr_d = wr_ctr_q - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= CtrWeakNt;
      end
    end else if (upd) begin
      ctr_q[wr_idx] <= wr_ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (upd)         branch_cnt_q <= branch_cnt_q + 32'd1;
      if (MispredictE) miss_cnt_q   <= miss_cnt_q + 32'd1;
    end
  end

  assign BranchCnt = branch_cnt_q;
  assign MissCnt   = miss_cnt_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: directed scenarios followed by random traffic checked
// against a counter-array model of the predictor.
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        BtbHitF;
  logic [31:0] BtbTargetF;
  logic        PredTakenF;
  logic [31:0] NPCF;
  logic [31:0] PCE;
  logic [2:0]  BranchTypeE;
  logic        BranchTakenE;
  logic [31:0] BranchTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        StallE;
  logic        MispredictE;
  logic [31:0] CorrectPCE;
  logic [31:0] BranchCnt;
  logic [31:0] MissCnt;

  bht_predictor dut (
    .clk          (clk),
    .rst          (rst),
    .PCF          (PCF),
    .BtbHitF      (BtbHitF),
    .BtbTargetF   (BtbTargetF),
    .PredTakenF   (PredTakenF),
    .NPCF         (NPCF),
    .PCE          (PCE),
    .BranchTypeE  (BranchTypeE),
    .BranchTakenE (BranchTakenE),
    .BranchTargetE(BranchTargetE),
    .PredTakenE   (PredTakenE),
    .PredTargetE  (PredTargetE),
    .StallE       (StallE),
    .MispredictE  (MispredictE),
    .CorrectPCE   (CorrectPCE),
    .BranchCnt    (BranchCnt),
    .MissCnt      (MissCnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mctr [128];
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[8:2]);
  endfunction

  function automatic logic model_pred(input logic [31:0] pc, input logic hit);
    return hit && (mctr[idx_of(pc)] >= 2);
  endfunction

  task automatic set_f(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    PCF = pc; BtbHitF = hit; BtbTargetF = tgt;
  endtask

  task automatic set_e(input logic [31:0] pc, input logic [2:0] typ, input logic tkn,
                       input logic [31:0] btgt, input logic pt, input logic [31:0] ptgt,
                       input logic stall);
    PCE = pc; BranchTypeE = typ; BranchTakenE = tkn; BranchTargetE = btgt;
    PredTakenE = pt; PredTargetE = ptgt; StallE = stall;
  endtask

  task automatic no_branch();
    set_e(32'h0, 3'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Checks combinational outputs, advances one clock, updates the model and checks counts.
  task automatic cycle(input logic chk_comb);
    logic        upd;
    logic        miss;
    logic        pf;
    logic [31:0] npc;
    logic [31:0] cpc;
    int          i;
    #1;
    upd  = (BranchTypeE != 3'd0) && !StallE;
    miss = upd && ((BranchTakenE != PredTakenE) ||
                   (BranchTakenE && PredTakenE && (PredTargetE != BranchTargetE)));
    pf   = model_pred(PCF, BtbHitF);
    npc  = pf ? BtbTargetF : PCF + 32'd4;
    cpc  = BranchTakenE ? BranchTargetE : PCE + 32'd4;
    if (chk_comb) begin
      chk("PredTakenF", {31'd0, PredTakenF}, {31'd0, pf});
      chk("NPCF", NPCF, npc);
      chk("MispredictE", {31'd0, MispredictE}, {31'd0, miss});
      chk("CorrectPCE", CorrectPCE, cpc);
    end
    @(posedge clk);
    if (rst) begin
      foreach (mctr[k]) mctr[k] = 1;
      m_bcnt = 0;
      m_mcnt = 0;
    end else begin
      if (upd) begin
        i = idx_of(PCE);
        mctr[i] = BranchTakenE ? ((mctr[i] == 3) ? 3 : mctr[i] + 1)
                               : ((mctr[i] == 0) ? 0 : mctr[i] - 1);
        m_bcnt = m_bcnt + 32'd1;
      end
      if (miss) m_mcnt = m_mcnt + 32'd1;
    end
    #1;
    chk("BranchCnt", BranchCnt, m_bcnt);
    chk("MissCnt", MissCnt, m_mcnt);
  endtask

  initial begin
    logic [31:0] pcs [5];
    logic [31:0] pc_r;
    logic [31:0] pce_r;
    logic        pt_r;
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h300; pcs[3] = 32'h500; pcs[4] = 32'h0;

    // Reset and post-reset prediction
    rst = 1'b1;
    set_f(32'h100, 1'b1, 32'h200);
    no_branch();
    cycle(1'b0);
    cycle(1'b1);
    rst = 1'b0;
    #1;
    chk("reset_pred", {31'd0, PredTakenF}, 32'd0);
    chk("reset_npc", NPCF, 32'h104);
    chk("reset_bcnt", BranchCnt, 32'd0);
    chk("reset_mcnt", MissCnt, 32'd0);

    // Four taken updates at 0x100, PredTakenE tracking the fetch prediction
    for (int n = 0; n < 4; n++) begin
      pt_r = model_pred(32'h100, 1'b1);
      set_e(32'h100, 3'd1, 1'b1, 32'h200, pt_r, pt_r ? 32'h200 : 32'h104, 1'b0);
      cycle(1'b1);
      chk("train_pred", {31'd0, PredTakenF}, 32'd1);
      chk("train_npc", NPCF, 32'h200);
    end
    chk("train_bcnt", BranchCnt, 32'd4);
    chk("train_mcnt", MissCnt, 32'd1);

    // One not-taken update from 11 -> 10, still predicted taken
    set_e(32'h100, 3'd1, 1'b0, 32'h200, 1'b1, 32'h200, 1'b0);
    #1;
    chk("nt_misp", {31'd0, MispredictE}, 32'd1);
    chk("nt_cpc", CorrectPCE, 32'h104);
    cycle(1'b1);
    chk("nt_pred", {31'd0, PredTakenF}, 32'd1);

    // Taken with wrong predicted target
    set_e(32'h100, 3'd2, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
    #1;
    chk("tgt_misp", {31'd0, MispredictE}, 32'd1);
    chk("tgt_cpc", CorrectPCE, 32'h200);
    cycle(1'b1);
    chk("tgt_mcnt", MissCnt, 32'd3);

    // Branch held in EX for three stalled cycles
    set_f(32'h500, 1'b1, 32'h600);
    for (int n = 0; n < 3; n++) begin
      set_e(32'h500, 3'd1, 1'b1, 32'h600, 1'b0, 32'h504, 1'b1);
      #1;
      chk("stall_misp", {31'd0, MispredictE}, 32'd0);
      cycle(1'b1);
      chk("stall_bcnt", BranchCnt, 32'd6);
    end
    StallE = 1'b0;
    cycle(1'b1);
    chk("unstall_bcnt", BranchCnt, 32'd7);
    chk("unstall_pred", {31'd0, PredTakenF}, 32'd1);
    no_branch();
    cycle(1'b1);
    chk("unstall_once", BranchCnt, 32'd7);

    // BranchCnt wrap from a forced all-ones value
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    m_bcnt = 32'hFFFF_FFFF;
    set_e(32'h104, 3'd3, 1'b0, 32'h0, 1'b0, 32'h108, 1'b0);
    cycle(1'b1);
    chk("wrap_bcnt", BranchCnt, 32'd0);

    // Reset dominates a same-cycle update
    rst = 1'b1;
    set_f(32'h100, 1'b1, 32'h200);
    set_e(32'h100, 3'd1, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0);
    cycle(1'b1);
    rst = 1'b0;
    no_branch();
    #1;
    chk("rstupd_bcnt", BranchCnt, 32'd0);
    chk("rstupd_mcnt", MissCnt, 32'd0);
    chk("rstupd_pred", {31'd0, PredTakenF}, 32'd0);

    // Random traffic over a few aliasing and distinct PCs
    for (int n = 0; n < 400; n++) begin
      pc_r  = ($urandom_range(0, 3) == 0) ? {$urandom(), 2'b00} >> 2 << 2
                                           : pcs[$urandom_range(0, 4)];
      pce_r = ($urandom_range(0, 3) == 0) ? {$urandom()} & 32'hFFFF_FFFC
                                           : pcs[$urandom_range(0, 4)];
      rst = ($urandom_range(0, 99) < 2);
      set_f(pc_r, 1'($urandom_range(0, 1)), $urandom());
      pt_r = ($urandom_range(0, 9) < 7) ? model_pred(pce_r, 1'b1) : 1'($urandom_range(0, 1));
      set_e(pce_r, ($urandom_range(0, 9) < 3) ? 3'd0 : 3'($urandom_range(1, 7)),
            1'($urandom_range(0, 1)), 32'h0000_0800,
            pt_r, ($urandom_range(0, 3) == 0) ? 32'h0000_0900 : 32'h0000_0800,
            ($urandom_range(0, 3) == 0));
      cycle(1'b1);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
